// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scanner.
package display_pkg;

  localparam int unsigned MAX_DIGITS = 8;

  typedef enum logic [0:0] {
    LIVRE,
    PENDENTE
  } estado_t;

  // Common-anode enables are active-low, so "all off" is all ones.
  function automatic logic [MAX_DIGITS-1:0] anodo_off(input int unsigned n);
    logic [MAX_DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < n) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/display_scanner_scan_timer.sv
// Slot/digit counters for the scanner; exposes next-cycle values so the
// integrator can register outputs that line up with the counters.
module scan_timer
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DWELL      = 50000,
  parameter int unsigned BLANK      = 2,
  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1,
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [IW-1:0] idx_nxt_o,
  output logic          cont_lt_blank_nxt_o,
  output logic          fim_quadro_o
);

  logic [CW-1:0] cont_q, cont_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          fim_slot;

  assign fim_slot     = (cont_q == CW'(DWELL - 1));
  assign fim_quadro_o = fim_slot && (idx_q == IW'(NUM_DIGITS - 1));

  always_comb begin
    cont_d = cont_q + CW'(1);
    idx_d  = idx_q;
    if (fim_slot) begin
      cont_d = '0;
      idx_d  = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  assign idx_nxt_o           = idx_d;
  assign cont_lt_blank_nxt_o = (32'(cont_d) < BLANK);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cont_q <= '0;
      idx_q  <= '0;
    end else begin
      cont_q <= cont_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Hex display scanner: frame-synchronous value update via valid/ready,
// leading-zero suppression and ghosting guard, registered outputs.
module display_scanner
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DWELL      = 50000,
  parameter int unsigned BLANK      = 2,
  parameter int unsigned LZ_BLANK   = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] valor_in,
  input  logic                    valido,
  output logic                    pronto,
  output logic [3:0]              digito,
  output logic [NUM_DIGITS-1:0]   anodo,
  output logic                    apagar,
  output logic                    quadro
);

  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VW = 4 * NUM_DIGITS;
  localparam logic [NUM_DIGITS-1:0] ANODO_OFF = NUM_DIGITS'(anodo_off(NUM_DIGITS));

  logic [IW-1:0] idx_nxt;
  logic          lt_blank_nxt;
  logic          fim_quadro;

  scan_timer #(
    .NUM_DIGITS(NUM_DIGITS),
    .DWELL     (DWELL),
    .BLANK     (BLANK)
  ) u_scan_timer (
    .clk_i              (clock),
    .rst_i              (reset),
    .idx_nxt_o          (idx_nxt),
    .cont_lt_blank_nxt_o(lt_blank_nxt),
    .fim_quadro_o       (fim_quadro)
  );

  estado_t               state_q, state_d;
  logic [VW-1:0]         active_q, active_d;
  logic [VW-1:0]         pending_q, pending_d;
  logic                  pronto_q, pronto_d;
  logic [3:0]            digito_q, digito_d;
  logic [NUM_DIGITS-1:0] anodo_q, anodo_d;
  logic                  apagar_q, apagar_d;
  logic                  quadro_q;
  logic [NUM_DIGITS-1:0] supr;
  logic                  upper_zero;

  // Handshake: capture off-boundary, commit only at the frame boundary.
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    pending_d = pending_q;
    unique case (state_q)
      LIVRE: begin
        if (valido) begin
          if (fim_quadro) begin
            active_d = valor_in;
          end else begin
            pending_d = valor_in;
            state_d   = PENDENTE;
          end
        end
      end
      PENDENTE: begin
        if (fim_quadro) begin
          active_d = pending_q;
          state_d  = LIVRE;
        end
      end
      default: state_d = LIVRE;
    endcase
    pronto_d = (state_d == LIVRE);
  end

  // Digit k is suppressed when it and every more significant nibble are zero.
  always_comb begin
    supr       = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero && (active_d[4*k +: 4] == 4'h0);
      supr[k]    = (LZ_BLANK != 0) && upper_zero;
    end
  end

  always_comb begin
    digito_d = active_d[4*idx_nxt +: 4];
    anodo_d  = ANODO_OFF;
    apagar_d = 1'b1;
    if (!lt_blank_nxt && !supr[idx_nxt]) begin
      anodo_d  = ~(NUM_DIGITS'(1) << idx_nxt);
      apagar_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= LIVRE;
      active_q  <= '0;
      pending_q <= '0;
      pronto_q  <= 1'b1;
      digito_q  <= 4'h0;
      anodo_q   <= ANODO_OFF;
      apagar_q  <= 1'b1;
      quadro_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pronto_q  <= pronto_d;
      digito_q  <= digito_d;
      anodo_q   <= anodo_d;
      apagar_q  <= apagar_d;
      quadro_q  <= fim_quadro;
    end
  end

  assign pronto = pronto_q;
  assign digito = digito_q;
  assign anodo  = anodo_q;
  assign apagar = apagar_q;
  assign quadro = quadro_q;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: directed scenarios plus random loads, checked
// against a cycle-count based model of the scan and frame-sync rules.
module tb_display_scanner;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned BL = 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [15:0]   valor_in;
  logic          valido;
  logic          pronto;
  logic [3:0]    digito;
  logic [N-1:0]  anodo;
  logic          apagar;
  logic          quadro;

  int checks = 0;
  int errors = 0;

  // Model state: cycles since reset, displayed value, buffered value.
  int          t;
  logic [15:0] m_active;
  logic [15:0] m_pending;
  bit          m_busy;

  display_scanner #(
    .NUM_DIGITS(N),
    .DWELL     (DW),
    .BLANK     (BL),
    .LZ_BLANK  (1)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .valor_in(valor_in),
    .valido  (valido),
    .pronto  (pronto),
    .digito  (digito),
    .anodo   (anodo),
    .apagar  (apagar),
    .quadro  (quadro)
  );

  always #5 clock = ~clock;

  task automatic check_outputs();
    int          cont;
    int          idx;
    logic [15:0] upper;
    logic [3:0]  e_dig;
    logic [N-1:0] e_an;
    logic        e_apg;
    logic        e_q;
    cont  = t % DW;
    idx   = (t / DW) % N;
    e_dig = 4'((m_active >> (4 * idx)) & 16'hF);
    upper = m_active >> (4 * idx);
    if (cont < BL || (idx != 0 && upper == 16'h0)) begin
      e_an  = '1;
      e_apg = 1'b1;
    end else begin
      e_an  = ~(N'(1) << idx);
      e_apg = 1'b0;
    end
    e_q = (t > 0) && (t % (DW * N) == 0);
    checks += 5;
    assert (digito === e_dig) else begin
      errors++;
      $error("FAIL digito t=%0d got %h exp %h", t, digito, e_dig);
    end
    assert (anodo === e_an) else begin
      errors++;
      $error("FAIL anodo t=%0d got %b exp %b", t, anodo, e_an);
    end
    assert (apagar === e_apg) else begin
      errors++;
      $error("FAIL apagar t=%0d got %b exp %b", t, apagar, e_apg);
    end
    assert (quadro === e_q) else begin
      errors++;
      $error("FAIL quadro t=%0d got %b exp %b", t, quadro, e_q);
    end
    assert (pronto === !m_busy) else begin
      errors++;
      $error("FAIL pronto t=%0d got %b exp %b", t, pronto, !m_busy);
    end
  endtask

  // One cycle: check current outputs, present inputs, advance model and clock.
  task automatic cycle(input bit v, input logic [15:0] d);
    bit boundary;
    check_outputs();
    valido   = v;
    valor_in = d;
    boundary = (t % DW == DW - 1) && ((t / DW) % N == N - 1);
    if (!m_busy) begin
      if (v) begin
        if (boundary) m_active = d;
        else begin
          m_pending = d;
          m_busy    = 1'b1;
        end
      end
    end else if (boundary) begin
      m_active = m_pending;
      m_busy   = 1'b0;
    end
    @(posedge clock);
    #1;
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    valido   = 1'b0;
    valor_in = 16'h0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset     = 1'b0;
    t         = 0;
    m_active  = 16'h0;
    m_pending = 16'h0;
    m_busy    = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    valido   = 1'b0;
    valor_in = 16'h0;
    #1;

    // Reset only: digit 0 shows 0, upper digits suppressed.
    do_reset();
    idle(16);

    // Mid-frame load, applied at the next frame.
    do_reset();
    idle(5);
    cycle(1'b1, 16'h1234);
    idle(26);

    // Leading-zero suppression.
    do_reset();
    cycle(1'b1, 16'h0050);
    idle(40);

    // Load on the boundary bypasses the buffer.
    do_reset();
    idle(15);
    cycle(1'b1, 16'hABCD);
    idle(8);

    // Value held while busy is taken when pronto returns.
    do_reset();
    idle(5);
    cycle(1'b1, 16'h1234);
    idle(1);
    for (int i = 7; i <= 16; i++) cycle(1'b1, 16'h9999);
    idle(24);

    // Reset with a pending value discards it.
    do_reset();
    idle(5);
    cycle(1'b1, 16'h7777);
    idle(4);
    do_reset();
    idle(40);

    // Random loads with varying numbers of leading zeros.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [15:0] d;
      d = 16'($urandom_range(0, 65535)) >> (4 * $urandom_range(0, 4));
      cycle($urandom_range(0, 3) == 0, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
